xctrl_banks: RTL and testbench

Parametrised successor of the extension-board control logic: decodes Gigatron ctrl codes (`nGOE` and `nGWE` both low) to drive RAM banking, SPI device selects and a readable control port. It adds a configurable bank width, a configurable number of SPI selects, and a hardware SPI byte-shift engine that coexists with bit-banged SPI. It sits between the Gigatron bus and the external SRAM/SPI pins, fully synchronous to one clock.

---
 rtl/xctrl_banks.sv | 187 ++++++++++++++++++
 tb/tb_xctrl_banks.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xctrl_banks.sv
// Gigatron extension-board control: ctrl-code decode, RAM banking, SPI selects,
// readable control port and a mode-0 SPI byte-shift engine sharing the pins with bit-bang SPI.
module xctrl_banks #(
    parameter int RAW    = 19,
    parameter int NSS    = 2,
    parameter int SPIDIV = 2
) (
    input  logic           CLK,
    input  logic           nRESET,
    input  logic [15:0]    GA,
    input  logic [7:0]     GBUSIN,
    input  logic           nGOE,
    input  logic           nGWE,
    input  logic [7:0]     RDIN,
    input  logic           MISO,
    output logic [RAW-1:0] RA,
    output logic [7:0]     RDOUT,
    output logic           nROE,
    output logic           nRWE,
    output logic [7:0]     GBUSOUT,
    output logic           SCK,
    output logic           MOSI,
    output logic [NSS-1:0] nSS,
    output logic           BUSY
);
    localparam int BW  = RAW - 15;
    localparam int BWL = (BW < 4) ? BW : 4;
    localparam int DW  = (SPIDIV > 1) ? $clog2(SPIDIV) : 1;

    typedef enum logic [1:0] {ENG_IDLE, ENG_LOW, ENG_HIGH} eng_t;

    eng_t           r_eng, w_eng_nxt;
    logic           r_ctrl_d;
    logic [1:0]     r_bank;
    logic           r_nzpbank;
    logic [NSS-1:0] r_nss;
    logic           r_sclk, r_sck, r_mosi;
    logic [BW-1:0]  r_bank0r, r_bank0w;
    logic [7:0]     r_rx;
    logic [6:0]     r_tx;
    logic [2:0]     r_bit;
    logic [DW-1:0]  r_div;

    logic           w_ctrl, w_cpulse, w_rst_ctrl, w_norm, w_ext, w_start;
    logic           w_busy, w_half, w_sample, w_shift;
    logic           w_zpb, w_ben, w_pen;
    logic [BW-1:0]  w_hi, w_b0r_new, w_b0w_new;

    assign w_ctrl     = !nGOE && !nGWE;
    assign w_cpulse   = w_ctrl && !r_ctrl_d;
    assign w_rst_ctrl = w_cpulse && (GA[1:0] == 2'b11);
    assign w_norm     = w_cpulse && !w_rst_ctrl && (GA[3:2] != 2'b00);
    assign w_ext      = w_cpulse && !w_rst_ctrl && (GA[3:2] == 2'b00);
    assign w_busy     = (r_eng != ENG_IDLE);
    assign w_start    = w_ext && (GA[7:4] == 4'hE) && !w_busy;
    assign w_half     = (r_div == DW'(SPIDIV - 1));

    always_comb begin
        w_b0r_new = '0;
        w_b0w_new = '0;
        w_b0r_new[BWL-1:0] = GA[8 +: BWL];
        w_b0w_new[BWL-1:0] = GA[12 +: BWL];
    end

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            r_ctrl_d  <= 1'b0;
            r_bank    <= 2'b01;
            r_nzpbank <= 1'b1;
            r_nss     <= '1;
            r_sclk    <= 1'b0;
            r_bank0r  <= '0;
            r_bank0w  <= '0;
        end else begin
            r_ctrl_d <= w_ctrl;
            if (w_rst_ctrl) begin
                r_bank0r <= '0;
                r_bank0w <= '0;
            end else if (w_norm) begin
                r_bank     <= GA[7:6];
                r_nzpbank  <= GA[5];
                r_nss[1:0] <= GA[3:2];
                r_sclk     <= GA[0];
            end else if (w_ext) begin
                if (GA[7:4] == 4'hF) begin
                    r_bank0r <= w_b0r_new;
                    r_bank0w <= w_b0w_new;
                end
                if (GA[7:4] == 4'hD) begin
                    for (int i = 2; i < NSS; i++) r_nss[i] <= GA[6+i];
                end
            end
        end
    end

    // Engine phases: each bit is SPIDIV cycles of SCK low followed by SPIDIV cycles high.
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) r_eng <= ENG_IDLE;
        else         r_eng <= w_eng_nxt;
    end

    always_comb begin
        w_eng_nxt = r_eng;
        w_sample  = 1'b0;
        w_shift   = 1'b0;
        case (r_eng)
            ENG_IDLE: if (w_start) w_eng_nxt = ENG_LOW;
            ENG_LOW: if (w_half) begin
                w_eng_nxt = ENG_HIGH;
                w_sample  = 1'b1;
            end
            ENG_HIGH: if (w_half) begin
                w_eng_nxt = (r_bit == 3'd7) ? ENG_IDLE : ENG_LOW;
                w_shift   = (r_bit != 3'd7);
            end
            default: w_eng_nxt = ENG_IDLE;
        endcase
        if (w_rst_ctrl) begin
            w_eng_nxt = ENG_IDLE;
            w_sample  = 1'b0;
            w_shift   = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            r_sck  <= 1'b0;
            r_mosi <= 1'b0;
            r_tx   <= '0;
            r_rx   <= '0;
            r_bit  <= '0;
            r_div  <= '0;
        end else begin
            r_div <= (w_busy && !w_half) ? r_div + DW'(1) : '0;
            if (w_sample) r_rx <= {r_rx[6:0], MISO};
            if (w_rst_ctrl) begin
                r_sck <= 1'b0;
            end else if (w_start) begin
                r_tx   <= GA[14:8];
                r_bit  <= '0;
                r_mosi <= GA[15];
                r_sck  <= 1'b0;
            end else if (w_shift) begin
                r_tx   <= {r_tx[5:0], 1'b0};
                r_mosi <= r_tx[6];
                r_bit  <= r_bit + 3'd1;
            end else if (w_norm && !w_busy) begin
                r_mosi <= GA[15];
                r_sck  <= GA[0] ~^ GA[4];
            end
        end
    end

    // Banking: the zero-page window flips which half of the address space is banked.
    assign w_zpb = !r_nzpbank && (GA[14:7] == 8'h01);
    assign w_ben = GA[15] ~^ w_zpb;

    always_comb begin
        w_hi = '0;
        if (w_ben) begin
            if (r_bank != 2'b00) w_hi = {{(BW-2){1'b0}}, r_bank};
            else                 w_hi = nGOE ? r_bank0w : r_bank0r;
        end
    end

    assign w_pen = r_sclk && ((GA == 16'h0000) || (GA[15:4] == 12'h00F));

    always_comb begin
        GBUSOUT = RDIN;
        if (w_pen) begin
            case (GA[3:0])
                4'hF:    GBUSOUT = {r_bank0w[3:0], r_bank0r[3:0]};
                4'hE:    GBUSOUT = r_rx;
                default: GBUSOUT = {r_bank, 3'b000, w_busy, 1'b0, MISO};
            endcase
        end
    end

    assign RA    = {w_hi, GA[14:0]};
    assign RDOUT = GBUSIN;
    assign nROE  = nGOE | w_pen;
    assign nRWE  = nGWE | !nGOE;
    assign SCK   = w_busy ? (r_eng == ENG_HIGH) : r_sck;
    assign MOSI  = r_mosi;
    assign nSS   = r_nss;
    assign BUSY  = w_busy;
endmodule

// File: tb/tb_xctrl_banks.sv
// Bench for xctrl_banks: directed scenarios plus randomized bus/ctrl traffic,
// every cycle compared against a behavioural model of the board.
module tb_xctrl_banks;
    localparam int RAW = 19;
    localparam int NSS = 4;
    localparam int S   = 2;

    logic           CLK = 1'b0;
    logic           nRESET;
    logic [15:0]    GA;
    logic [7:0]     GBUSIN, RDIN;
    logic           nGOE, nGWE, MISO;
    logic [RAW-1:0] RA;
    logic [7:0]     RDOUT, GBUSOUT;
    logic           nROE, nRWE, SCK, MOSI, BUSY;
    logic [NSS-1:0] nSS;

    int n_chk = 0;
    int n_pass = 0;

    xctrl_banks #(.RAW(RAW), .NSS(NSS), .SPIDIV(S)) dut (
        .CLK(CLK), .nRESET(nRESET), .GA(GA), .GBUSIN(GBUSIN), .nGOE(nGOE), .nGWE(nGWE),
        .RDIN(RDIN), .MISO(MISO), .RA(RA), .RDOUT(RDOUT), .nROE(nROE), .nRWE(nRWE),
        .GBUSOUT(GBUSOUT), .SCK(SCK), .MOSI(MOSI), .nSS(nSS), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    // Behavioural model state
    logic       m_ctrl_d, m_nzp, m_sclk, m_sck, m_mosi, m_busy;
    logic [1:0] m_bank;
    logic [3:0] m_nss, m_b0r, m_b0w;
    logic [7:0] m_tx, m_rx;
    int         m_k;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        m_ctrl_d = 0; m_nzp = 1; m_sclk = 0; m_sck = 0; m_mosi = 0; m_busy = 0;
        m_bank = 2'b01; m_nss = 4'hF; m_b0r = 0; m_b0w = 0; m_tx = 0; m_rx = 0; m_k = 0;
    endtask

    task automatic model_edge();
        logic ctrl, cp, bsy0;
        int bi;
        ctrl = !nGOE && !nGWE;
        cp = ctrl && !m_ctrl_d;
        m_ctrl_d = ctrl;
        bsy0 = m_busy;
        if (cp && GA[1:0] == 2'b11) begin
            m_b0r = 0; m_b0w = 0; m_busy = 0; m_sck = 0;
        end else begin
            if (bsy0) begin
                m_k++;
                if (m_k % (2*S) == S) m_rx = {m_rx[6:0], MISO};
                m_sck = (m_k % (2*S)) >= S;
                bi = m_k / (2*S);
                if (bi > 7) bi = 7;
                m_mosi = m_tx[7-bi];
                if (m_k == 16*S) begin m_busy = 0; m_sck = 0; end
            end
            if (cp) begin
                if (GA[3:2] != 2'b00) begin
                    m_bank = GA[7:6]; m_nzp = GA[5]; m_nss[1:0] = GA[3:2]; m_sclk = GA[0];
                    if (!bsy0) begin m_mosi = GA[15]; m_sck = (GA[0] == GA[4]); end
                end else begin
                    case (GA[7:4])
                        4'hF: begin m_b0r = GA[11:8]; m_b0w = GA[15:12]; end
                        4'hE: if (!bsy0) begin
                            m_busy = 1; m_k = 0; m_tx = GA[15:8]; m_mosi = GA[15]; m_sck = 0;
                        end
                        4'hD: m_nss[3:2] = GA[9:8];
                        default: ;
                    endcase
                end
            end
        end
    endtask

    function automatic logic [31:0] exp_ra();
        logic zpb, ben;
        logic [3:0] hi;
        zpb = !m_nzp && (GA[14:7] == 8'h01);
        ben = (GA[15] == zpb);
        if (!ben) hi = 0;
        else if (m_bank != 0) hi = {2'b00, m_bank};
        else hi = nGOE ? m_b0w : m_b0r;
        return 32'(hi) * 32768 + 32'(GA[14:0]);
    endfunction

    function automatic logic [31:0] exp_gbus();
        logic pen;
        pen = m_sclk && (GA == 16'h0000 || GA[15:4] == 12'h00F);
        if (!pen) return 32'(RDIN);
        if (GA[3:0] == 4'hF) return 32'({m_b0w, m_b0r});
        if (GA[3:0] == 4'hE) return 32'(m_rx);
        return 32'({m_bank, 3'b000, m_busy, 1'b0, MISO});
    endfunction

    task automatic check_all();
        logic pen;
        pen = m_sclk && (GA == 16'h0000 || GA[15:4] == 12'h00F);
        check("ra", 32'(RA), exp_ra());
        check("gbusout", 32'(GBUSOUT), exp_gbus());
        check("rdout", 32'(RDOUT), 32'(GBUSIN));
        check("nroe", 32'(nROE), 32'(nGOE | pen));
        check("nrwe", 32'(nRWE), 32'(nGWE | !nGOE));
        check("sck", 32'(SCK), 32'(m_sck));
        check("mosi", 32'(MOSI), 32'(m_mosi));
        check("nss", 32'(nSS), 32'(m_nss));
        check("busy", 32'(BUSY), 32'(m_busy));
    endtask

    task automatic cyc();
        #1 check_all();
        @(posedge CLK);
        if (nRESET) model_edge();
        else model_reset();
        #1;
    endtask

    task automatic do_ctrl(input logic [15:0] a);
        GA = a; nGOE = 0; nGWE = 0; cyc();
        GA = 16'h0000; nGOE = 1; nGWE = 1; cyc();
    endtask

    function automatic logic [15:0] rand_ctrl();
        logic [15:0] a;
        a = 16'($urandom);
        case ($urandom_range(0, 14))
            0, 1, 2, 3, 4, 5: begin
                if (a[3:2] == 2'b00) a[3:2] = 2'b01;
                if (a[1:0] == 2'b11) a[1] = 1'b0;
            end
            6, 7, 8: begin a[3:0] = 4'h0; a[7:4] = 4'hE; end
            9, 10:   begin a[3:0] = 4'h0; a[7:4] = 4'hF; end
            11:      begin a[3:0] = 4'h0; a[7:4] = 4'hD; end
            12, 13:  a[3:0] = 4'h0;
            default: begin
                a[3:0] = 4'b0011;
                if (a[7:4] >= 4'hD) a[7:4] = 4'h0;
            end
        endcase
        return a;
    endfunction

    initial begin
        int busy_cnt, hold;
        logic [7:0] bits;
        logic prev_sck;
        GA = 0; GBUSIN = 8'h33; RDIN = 8'h5A; nGOE = 1; nGWE = 1; MISO = 0;
        nRESET = 1;
        #2 nRESET = 0;
        model_reset();
        repeat (3) cyc();
        nRESET = 1;

        // Reset state and plain SRAM read
        nGOE = 0; nGWE = 1; GA = 16'h0000;
        #1 check("rst_gbus", 32'(GBUSOUT), 32'h5A);
        check("rst_ra", 32'(RA), 32'h08000);
        check("rst_nss", 32'(nSS), 32'hF);
        check("rst_busy", 32'(BUSY), 32'h0);
        cyc();

        // Port read after enabling SCLK
        do_ctrl(16'h007D);
        GA = 16'h0000; nGOE = 0; nGWE = 1; MISO = 1;
        #1 check("port_stat", 32'(GBUSOUT), 32'h41);
        cyc();

        // BANK0R/BANK0W selection with BANK=0
        do_ctrl(16'h21F0);
        do_ctrl(16'h003C);
        GA = 16'h0123; nGOE = 0; nGWE = 1;
        #1 check("ra_b0r", 32'(RA), 32'h08123);
        cyc();
        GA = 16'h0123; nGOE = 1; nGWE = 0;
        #1 check("ra_b0w", 32'(RA), 32'h10123);
        cyc();
        GA = 16'h8123; nGOE = 0; nGWE = 1;
        #1 check("ra_unbanked", 32'(RA), 32'h00123);
        cyc();

        // Zero-page banking window with BANK=2, SCLK=1
        do_ctrl(16'h008D);
        GA = 16'h0085; nGOE = 0; nGWE = 1;
        #1 check("ra_zp_lo", 32'(RA), 32'h00085);
        cyc();
        GA = 16'h8085;
        #1 check("ra_zp_hi", 32'(RA), 32'h10085);
        cyc();
        GA = 16'h0100;
        #1 check("ra_nozp", 32'(RA), 32'h10100);
        cyc();

        // Engine transfer with MISO loopback and an ignored second start
        busy_cnt = 0; bits = 0; prev_sck = 0;
        GA = 16'hA5E0; nGOE = 0; nGWE = 0; cyc();
        GA = 16'h00FE; nGOE = 1; nGWE = 1;
        for (int i = 0; i < 40; i++) begin
            if (i == 10) begin GA = 16'h3CE0; nGOE = 0; nGWE = 0; end
            if (i == 11) begin GA = 16'h00FE; nGOE = 1; nGWE = 1; end
            MISO = MOSI;
            if (BUSY) busy_cnt++;
            if (SCK && !prev_sck) bits = {bits[6:0], MOSI};
            prev_sck = SCK;
            cyc();
        end
        check("xfer_busy_len", 32'(busy_cnt), 32'(16*S));
        check("xfer_mosi_bits", 32'(bits), 32'hA5);
        GA = 16'h00FE; nGOE = 0; nGWE = 1;
        #1 check("xfer_rx", 32'(GBUSOUT), 32'hA5);
        cyc();

        // Abort by reset ctrl
        GA = 16'h5AE0; nGOE = 0; nGWE = 0; cyc();
        GA = 16'h0000; nGOE = 1; nGWE = 1;
        repeat (9) begin MISO = 1'($urandom); cyc(); end
        #1 check("abort_pre_busy", 32'(BUSY), 32'h1);
        GA = 16'h0003; nGOE = 0; nGWE = 0; cyc();
        GA = 16'h00FF; nGOE = 0; nGWE = 1;
        #1 check("abort_busy", 32'(BUSY), 32'h0);
        check("abort_sck", 32'(SCK), 32'h0);
        check("abort_banks", 32'(GBUSOUT), 32'h00);
        cyc();
        GA = 16'h00FE;
        cyc();

        // Held ctrl acts once
        busy_cnt = 0;
        GA = 16'h00E0; nGOE = 0; nGWE = 0;
        for (int i = 0; i < 60; i++) begin
            if (i == 5) begin GA = 16'h0000; nGOE = 1; nGWE = 1; end
            if (BUSY) busy_cnt++;
            cyc();
        end
        check("hold_one_xfer", 32'(busy_cnt), 32'(16*S));

        // Extended selects
        do_ctrl(16'h02D0);
        #1 check("nss_ext", 32'(nSS[3:2]), 32'h2);
        cyc();

        // Asynchronous reset mid-transfer
        do_ctrl(16'hFFE0);
        repeat (5) cyc();
        nRESET = 0;
        model_reset();
        #1 check("arst_busy", 32'(BUSY), 32'h0);
        check("arst_sck", 32'(SCK), 32'h0);
        check("arst_mosi", 32'(MOSI), 32'h0);
        check("arst_nss", 32'(nSS), 32'hF);
        repeat (2) cyc();
        nRESET = 1;
        cyc();

        // Randomized traffic
        hold = 0;
        for (int i = 0; i < 2500; i++) begin
            RDIN = 8'($urandom); GBUSIN = 8'($urandom); MISO = 1'($urandom);
            if (hold > 0) begin
                hold--;
            end else if ($urandom_range(0, 99) < 15) begin
                GA = rand_ctrl(); nGOE = 0; nGWE = 0;
                hold = $urandom_range(0, 2);
            end else begin
                case ($urandom_range(0, 3))
                    0: GA = 16'h0000;
                    1: GA = {12'h00F, 4'($urandom)};
                    2: GA = {1'($urandom), 8'h01, 7'($urandom)};
                    default: GA = 16'($urandom);
                endcase
                case ($urandom_range(0, 2))
                    0: begin nGOE = 0; nGWE = 1; end
                    1: begin nGOE = 1; nGWE = 0; end
                    default: begin nGOE = 1; nGWE = 1; end
                endcase
            end
            cyc();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
